note_field: RTL

NOTE_FIELD -- requirements
Module: note_field

---
 rtl/note_field_pkg.sv | 23 ++
 rtl/note_field_if.sv | 38 +++
 rtl/note_field_lane.sv | 132 +++++++++++++
 rtl/note_field.sv | 115 +++++++++++
 4 files changed

// File: rtl/note_field_pkg.sv
// note_field shared types and default geometry.
// Judgement encodings plus screen/timing defaults.
package note_field_pkg;

  typedef enum logic [1:0] {
    JK_NONE    = 2'b00,
    JK_PERFECT = 2'b01,
    JK_GOOD    = 2'b10,
    JK_MISS    = 2'b11
  } judge_e;

  localparam int D_LANES       = 4;
  localparam int D_SLOTS       = 4;
  localparam int D_HIT_Y       = 400;
  localparam int D_PERFECT_WIN = 4;
  localparam int D_GOOD_WIN    = 12;
  localparam int D_SPEED       = 4;
  localparam int D_LANE_X0     = 160;
  localparam int D_LANE_W      = 80;
  localparam int D_NOTE_W      = 64;
  localparam int D_NOTE_H      = 16;

endpackage

// File: rtl/note_field_if.sv
// note_field bus: frame tick, spawn handshake, keys,
// pixel probe and judgement/score outputs.
interface note_field_if #(
  parameter int LANES = note_field_pkg::D_LANES
);
  logic               animate;
  logic [1:0]         slowFactor;
  logic               spawn_valid;
  logic [LANES-1:0]   spawn_mask;
  logic               spawn_ready;
  logic               keyPressed;
  logic [LANES-1:0]   keyValue;
  logic [9:0]         x;
  logic [9:0]         y;
  logic               is_note;
  logic [LANES-1:0]   judge_valid;
  logic [2*LANES-1:0] judge_kind;
  logic [15:0]        score;
  logic [7:0]         combo;

  modport master (
    output animate, slowFactor,
    output spawn_valid, spawn_mask,
    output keyPressed, keyValue, x, y,
    input  spawn_ready, is_note,
    input  judge_valid, judge_kind,
    input  score, combo
  );

  modport slave (
    input  animate, slowFactor,
    input  spawn_valid, spawn_mask,
    input  keyPressed, keyValue, x, y,
    output spawn_ready, is_note,
    output judge_valid, judge_kind,
    output score, combo
  );
endinterface

// File: rtl/note_field_lane.sv
// note_lane: one arrow lane's slot store, press target
// selection, advance/miss handling and judgement pulse.
module note_lane
  import note_field_pkg::*;
#(
  parameter int SLOTS       = D_SLOTS,
  parameter int HIT_Y       = D_HIT_Y,
  parameter int PERFECT_WIN = D_PERFECT_WIN,
  parameter int GOOD_WIN    = D_GOOD_WIN,
  parameter int SPEED       = D_SPEED,
  parameter int LANE_XL     = D_LANE_X0,
  parameter int NOTE_W      = D_NOTE_W,
  parameter int NOTE_H      = D_NOTE_H
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_adv,
  input  logic       i_spawn,
  input  logic       i_press,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_has_free,
  output logic       o_pix,
  output logic [1:0] o_kind,
  output logic       o_jv,
  output logic [1:0] o_jk
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [9:0]  HY = 10'(HIT_Y);
  localparam logic [9:0]  PW = 10'(PERFECT_WIN);
  localparam logic [9:0]  GW = 10'(GOOD_WIN);
  localparam logic [9:0]  SP = 10'(SPEED);
  localparam logic [9:0]  MY = 10'(HIT_Y + GOOD_WIN);
  localparam logic [10:0] XL = 11'(LANE_XL);
  localparam logic [10:0] XH = 11'(LANE_XL + NOTE_W);
  localparam logic [10:0] NH = 11'(NOTE_H);

  logic [SLOTS-1:0] r_act;
  logic [SLOTS-1:0] w_act;
  logic [9:0]       r_y [SLOTS];
  logic [9:0]       w_y [SLOTS];
  logic             r_jv;
  judge_e           r_jk;

  logic             w_found;
  logic [IW-1:0]    w_tgt;
  logic [9:0]       w_ty;
  logic [9:0]       w_d;
  logic             w_hit;
  logic             w_miss;
  logic             w_fok;
  logic [IW-1:0]    w_fidx;
  logic             w_pix;
  judge_e           w_hk;
  judge_e           w_kind;

  // Target is the lowest note on screen; strict > keeps lowest index on ties.
  always_comb begin
    w_found = 1'b0;
    w_tgt   = '0;
    w_ty    = '0;
    w_fok   = 1'b0;
    w_fidx  = '0;
    w_pix   = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (r_act[s] && (!w_found || r_y[s] > w_ty)) begin
        w_found = 1'b1;
        w_tgt   = IW'(s);
        w_ty    = r_y[s];
      end
      if (!r_act[s] && !w_fok) begin
        w_fok  = 1'b1;
        w_fidx = IW'(s);
      end
      if (r_act[s] &&
          {1'b0, i_x} >= XL && {1'b0, i_x} < XH &&
          {1'b0, i_y} >= {1'b0, r_y[s]} &&
          {1'b0, i_y} < {1'b0, r_y[s]} + NH)
        w_pix = 1'b1;
    end
    w_d   = (w_ty >= HY) ? w_ty - HY : HY - w_ty;
    w_hit = i_press && w_found && (w_d <= GW);
    w_hk  = (w_d <= PW) ? JK_PERFECT : JK_GOOD;
  end

  // A hit note is freed before the advance, so it can never also miss.
  always_comb begin
    w_act  = r_act;
    w_y    = r_y;
    w_miss = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (r_act[s]) begin
        if (w_hit && w_tgt == IW'(s)) begin
          w_act[s] = 1'b0;
        end else if (i_adv) begin
          w_y[s] = r_y[s] + SP;
          if (r_y[s] + SP > MY) begin
            w_act[s] = 1'b0;
            w_miss   = 1'b1;
          end
        end
      end
    end
    if (i_spawn && w_fok) begin
      w_act[w_fidx] = 1'b1;
      w_y[w_fidx]   = '0;
    end
    w_kind = w_hit ? w_hk : (w_miss ? JK_MISS : JK_NONE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_act <= '0;
      r_y   <= '{default: '0};
      r_jv  <= 1'b0;
      r_jk  <= JK_NONE;
    end else begin
      r_act <= w_act;
      r_y   <= w_y;
      r_jv  <= w_hit | w_miss;
      r_jk  <= w_kind;
    end
  end

  assign o_has_free = ~&w_act;
  assign o_pix      = w_pix;
  assign o_kind     = w_kind;
  assign o_jv       = r_jv;
  assign o_jk       = r_jk;

endmodule

// File: rtl/note_field.sv
// note_field top: advance divider, spawn handshake,
// lane array, score/combo accounting and pixel probe.
module note_field
  import note_field_pkg::*;
#(
  parameter int LANES       = D_LANES,
  parameter int SLOTS       = D_SLOTS,
  parameter int HIT_Y       = D_HIT_Y,
  parameter int PERFECT_WIN = D_PERFECT_WIN,
  parameter int GOOD_WIN    = D_GOOD_WIN,
  parameter int SPEED       = D_SPEED,
  parameter int LANE_X0     = D_LANE_X0,
  parameter int LANE_W      = D_LANE_W,
  parameter int NOTE_W      = D_NOTE_W,
  parameter int NOTE_H      = D_NOTE_H
) (
  input logic        clk,
  input logic        note_rst,
  note_field_if.slave bus
);

  logic [1:0]         r_div;
  logic               r_ready;
  logic [15:0]        r_score;
  logic [7:0]         r_combo;
  logic               r_is_note;

  logic               w_adv;
  logic               w_acc;
  logic [LANES-1:0]   w_free;
  logic [LANES-1:0]   w_pix;
  logic [LANES-1:0]   w_jv;
  logic [2*LANES-1:0] w_jk;
  logic [1:0]         w_kind [LANES];
  logic [16:0]        w_sum;
  logic [8:0]         w_hits;
  logic [8:0]         w_csum;
  logic               w_anymiss;

  assign w_adv = bus.animate && (r_div >= bus.slowFactor);
  assign w_acc = bus.spawn_valid && r_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    note_lane #(
      .SLOTS      (SLOTS),
      .HIT_Y      (HIT_Y),
      .PERFECT_WIN(PERFECT_WIN),
      .GOOD_WIN   (GOOD_WIN),
      .SPEED      (SPEED),
      .LANE_XL    (LANE_X0 + g * LANE_W),
      .NOTE_W     (NOTE_W),
      .NOTE_H     (NOTE_H)
    ) u_lane (
      .clk       (clk),
      .i_rst     (note_rst),
      .i_adv     (w_adv),
      .i_spawn   (w_acc && bus.spawn_mask[g]),
      .i_press   (bus.keyPressed && bus.keyValue[g]),
      .i_x       (bus.x),
      .i_y       (bus.y),
      .o_has_free(w_free[g]),
      .o_pix     (w_pix[g]),
      .o_kind    (w_kind[g]),
      .o_jv      (w_jv[g]),
      .o_jk      (w_jk[2*g +: 2])
    );
  end

  // Any miss this cycle restarts the combo before this cycle's hits count.
  always_comb begin
    w_sum     = {1'b0, r_score};
    w_hits    = '0;
    w_anymiss = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      unique case (w_kind[l])
        JK_PERFECT: begin
          w_sum  = w_sum + 17'd2;
          w_hits = w_hits + 9'd1;
        end
        JK_GOOD: begin
          w_sum  = w_sum + 17'd1;
          w_hits = w_hits + 9'd1;
        end
        JK_MISS: w_anymiss = 1'b1;
        default: ;
      endcase
    end
    w_csum = (w_anymiss ? 9'd0 : {1'b0, r_combo}) + w_hits;
  end

  always_ff @(posedge clk) begin
    if (note_rst) begin
      r_div     <= '0;
      r_ready   <= 1'b1;
      r_score   <= '0;
      r_combo   <= '0;
      r_is_note <= 1'b0;
    end else begin
      if (bus.animate)
        r_div <= w_adv ? 2'd0 : r_div + 2'd1;
      r_ready   <= &w_free;
      r_score   <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      r_combo   <= w_csum[8] ? 8'hFF : w_csum[7:0];
      r_is_note <= |w_pix;
    end
  end

  assign bus.spawn_ready = r_ready;
  assign bus.is_note     = r_is_note;
  assign bus.judge_valid = w_jv;
  assign bus.judge_kind  = w_jk;
  assign bus.score       = r_score;
  assign bus.combo       = r_combo;

endmodule
